seq_mult: RTL

- Multi-cycle shift-add multiplier for MULT/MULTU in the dynamic pipeline; the arithmetic inverse of the divide unit.
- Accepts two 32-bit operands with a start pulse.
- Iterates one multiplier bit per clock and returns the 64-bit product split into HI and LO, with a one-cycle done pulse.
- The pipeline holds the issuing instruction while busy is high and may cancel on flush.

---
 rtl/seq_mult.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/seq_mult.sv
// -----------------------------------------------------------------------------
// seq_mult
//
// Multi-cycle shift-add multiplier serving MULT / MULTU in the dynamic
// pipeline. One multiplier bit is retired per clock, so a full product takes
// WIDTH clock edges after the start edge. Signed operation is handled by
// multiplying magnitudes and negating the 2*WIDTH result at the end.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   start         operation request, accepted in IDLE or DONE
//   cancel        synchronous abort of an in-flight operation (flush)
//   sign          1 = signed (MULT), 0 = unsigned (MULTU); sampled with start
//   multiplicand  operand A; sampled with start
//   multiplier    operand B; sampled with start
//   busy          high while the multiply is iterating
//   done          one-cycle pulse; hi/lo valid from this cycle on
//   hi            product[2*WIDTH-1:WIDTH]
//   lo            product[WIDTH-1:0]
// -----------------------------------------------------------------------------
module seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic             sign,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = 2 * WIDTH;

    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    ZERO_CNT = {CW{1'b0}};
    localparam logic [CW-1:0]    ONE_CNT  = CW'(1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
    localparam logic [PW-1:0]    ZERO_P   = {PW{1'b0}};
    localparam logic [PW-1:0]    ONE_P    = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Magnitude of an operand; the most negative value maps onto itself,
    // which is exactly right once read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        logic [WIDTH-1:0] m;
        if (is_signed && v[WIDTH-1]) begin
            m = ~v + ONE_W;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Two's complement of a full-width product (zero negates to zero).
    function automatic logic [PW-1:0] negate_p(input logic [PW-1:0] v);
        return ~v + ONE_P;
    endfunction

    state_t           state_r, state_s;
    logic [PW-1:0]    acc_r, acc_s;
    logic [PW-1:0]    mcand_r, mcand_s;
    logic [WIDTH-1:0] mplier_r, mplier_s;
    logic [CW-1:0]    count_r, count_s;
    logic             neg_r, neg_s;
    logic [WIDTH-1:0] hi_r, hi_s;
    logic [WIDTH-1:0] lo_r, lo_s;

    logic [PW-1:0]    partial_s;
    logic [PW-1:0]    sum_s;
    logic [PW-1:0]    result_s;
    logic             last_s;

    // Datapath for the current iteration: add the shifted multiplicand when
    // the multiplier LSB is set, and form the signed-corrected result.
    always_comb begin
        partial_s = ZERO_P;
        if (mplier_r[0]) begin
            partial_s = mcand_r;
        end else begin
            partial_s = ZERO_P;
        end
        sum_s    = acc_r + partial_s;
        result_s = neg_r ? negate_p(sum_s) : sum_s;
        last_s   = (count_r == LAST_CNT);
    end

    // Next-state and next-register logic; everything holds unless changed.
    always_comb begin
        state_s  = state_r;
        acc_s    = acc_r;
        mcand_s  = mcand_r;
        mplier_s = mplier_r;
        count_s  = count_r;
        neg_s    = neg_r;
        hi_s     = hi_r;
        lo_s     = lo_r;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                // start wins over cancel outside CALC; DONE accepts a
                // back-to-back issue with no idle bubble.
                if (start) begin
                    mcand_s  = {ZERO_W, magnitude(multiplicand, sign)};
                    mplier_s = magnitude(multiplier, sign);
                    neg_s    = sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                    acc_s    = ZERO_P;
                    count_s  = ZERO_CNT;
                    state_s  = ST_CALC;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_CALC: begin
                // cancel takes priority over the completing edge.
                if (cancel) begin
                    state_s = ST_IDLE;
                end else begin
                    acc_s    = sum_s;
                    mcand_s  = mcand_r << 1;
                    mplier_s = mplier_r >> 1;
                    count_s  = count_r + ONE_CNT;
                    if (last_s) begin
                        hi_s    = result_s[PW-1:WIDTH];
                        lo_s    = result_s[WIDTH-1:0];
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CALC;
                    end
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            acc_r    <= ZERO_P;
            mcand_r  <= ZERO_P;
            mplier_r <= ZERO_W;
            count_r  <= ZERO_CNT;
            neg_r    <= 1'b0;
            hi_r     <= ZERO_W;
            lo_r     <= ZERO_W;
        end else begin
            state_r  <= state_s;
            acc_r    <= acc_s;
            mcand_r  <= mcand_s;
            mplier_r <= mplier_s;
            count_r  <= count_s;
            neg_r    <= neg_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
        end
    end

    assign busy = (state_r == ST_CALC);
    assign done = (state_r == ST_DONE);
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule
